// File: rtl/ram_cmd_arbiter.sv
// Two-requester round-robin arbiter in front of a byte-wide command RAM.
// A captured transaction is sent as an address beat then a data beat; reads
// then wait (bounded by RD_TIMEOUT) for the RAM's read-data strobe.
module ram_cmd_arbiter #(
  parameter int RD_TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       rst,

  input  logic       a_req,
  input  logic       a_rd,
  input  logic [7:0] a_addr,
  input  logic [7:0] a_wdata,
  output logic       a_gnt,
  output logic       a_done,
  output logic       a_err,
  output logic [7:0] a_rdata,

  input  logic       b_req,
  input  logic       b_rd,
  input  logic [7:0] b_addr,
  input  logic [7:0] b_wdata,
  output logic       b_gnt,
  output logic       b_done,
  output logic       b_err,
  output logic [7:0] b_rdata,

  output logic       busy,

  output logic       ram_rx_valid,
  output logic [9:0] ram_din,
  input  logic       ram_tx_valid,
  input  logic [7:0] ram_dout
);

  localparam int CNT_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    WAIT_RD,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic             owner_q, owner_d;     // 0 = A, 1 = B
  logic             rd_q, rd_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             prio_b_q, prio_b_d;   // 1 = B wins a tie next time
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [7:0]       a_rdata_q, a_rdata_d;
  logic [7:0]       b_rdata_q, b_rdata_d;

  // B wins when it is alone, or when both ask and A was served last.
  logic pick_b;
  assign pick_b = b_req & (~a_req | prio_b_q);

  // State and transaction registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      rd_q      <= 1'b0;
      addr_q    <= 8'h00;
      wdata_q   <= 8'h00;
      prio_b_q  <= 1'b0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      // NOTE: the read-data holding registers are reset too; they are visible
      // on the ports and must read 8'h00 before the first read completes.
      a_rdata_q <= 8'h00;
      b_rdata_q <= 8'h00;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge value of the others, independent of statement order.
      state_q   <= state_d;
      owner_q   <= owner_d;
      rd_q      <= rd_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      prio_b_q  <= prio_b_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  // Next-state logic: arbitration, capture, read wait and timeout.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    owner_d   = owner_q;
    rd_d      = rd_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    prio_b_d  = prio_b_q;
    cnt_d     = '0;
    err_d     = err_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;

    case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          owner_d  = pick_b;
          rd_d     = pick_b ? b_rd    : a_rd;
          addr_d   = pick_b ? b_addr  : a_addr;
          wdata_d  = pick_b ? b_wdata : a_wdata;
          prio_b_d = ~pick_b;
          err_d    = 1'b0;
          state_d  = ADDR;
        end
      end
      ADDR: state_d = DATA;
      DATA: state_d = rd_q ? WAIT_RD : DONE;
      WAIT_RD: begin
        if (ram_tx_valid) begin
          if (owner_q) b_rdata_d = ram_dout;
          else         a_rdata_d = ram_dout;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // RAM command decode from state and the captured transaction only.
  always_comb begin
    ram_rx_valid = 1'b0;
    ram_din      = 10'h000;
    case (state_q)
      ADDR: begin
        ram_rx_valid = 1'b1;
        ram_din      = {rd_q, 1'b0, addr_q};
      end
      DATA: begin
        ram_rx_valid = 1'b1;
        ram_din      = rd_q ? 10'h300 : {2'b01, wdata_q};
      end
      default: begin
        ram_rx_valid = 1'b0;
        ram_din      = 10'h000;
      end
    endcase
  end

  // ADDR and DONE each last exactly one cycle, so these decode to pulses.
  assign a_gnt   = (state_q == ADDR) && !owner_q;
  assign b_gnt   = (state_q == ADDR) &&  owner_q;
  assign a_done  = (state_q == DONE) && !owner_q;
  assign b_done  = (state_q == DONE) &&  owner_q;
  assign a_err   = a_done && err_q;
  assign b_err   = b_done && err_q;
  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_ram_cmd_arbiter.sv
// Directed bench for ram_cmd_arbiter: a table of single transactions plus
// hand-written sequences for round-robin, mid-transaction reset and stray
// RAM strobes.
module tb_ram_cmd_arbiter;

  logic       clk, rst;
  logic       a_req, a_rd, b_req, b_rd;
  logic [7:0] a_addr, a_wdata, b_addr, b_wdata;
  logic       a_gnt, a_done, a_err, b_gnt, b_done, b_err;
  logic [7:0] a_rdata, b_rdata;
  logic       busy, ram_rx_valid, ram_tx_valid;
  logic [9:0] ram_din;
  logic [7:0] ram_dout;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] ea, eb;   // expected held rdata per requester

  ram_cmd_arbiter #(.RD_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_rd(a_rd), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_done(a_done), .a_err(a_err), .a_rdata(a_rdata),
    .b_req(b_req), .b_rd(b_rd), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_done(b_done), .b_err(b_err), .b_rdata(b_rdata),
    .busy(busy), .ram_rx_valid(ram_rx_valid), .ram_din(ram_din),
    .ram_tx_valid(ram_tx_valid), .ram_dout(ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       owner;      // 0 = A, 1 = B
    logic       rd;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] dout;       // value the RAM model returns
    int         tx_cycle;   // WAIT_RD cycle (1-based) that strobes; 0 = never
    logic       early;      // strobe ram_tx_valid during IDLE/ADDR
    logic [9:0] exp_din_a;
    logic [9:0] exp_din_d;
    int         exp_wait;   // WAIT_RD cycles before DONE
    logic       exp_err;
    logic [7:0] exp_rdata;  // owner's rdata at done
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Runs one transaction; called at a negedge with the DUT idle, returns at
  // the negedge of the IDLE cycle that follows DONE.
  task automatic run_txn(input string tag, input vec_t v);
    int   n_wait;
    logic seen;
    check({tag, "_pre_idle"}, busy, 1'b0);
    a_req = !v.owner; b_req = v.owner;
    a_rd = v.rd; b_rd = v.rd;
    a_addr = v.addr; b_addr = v.addr;
    a_wdata = v.wdata; b_wdata = v.wdata;
    if (v.early) begin ram_tx_valid = 1'b1; ram_dout = v.dout; end
    @(negedge clk);  // ADDR
    check({tag, "_gnt_own"}, v.owner ? b_gnt : a_gnt, 1'b1);
    check({tag, "_gnt_oth"}, v.owner ? a_gnt : b_gnt, 1'b0);
    check({tag, "_rxv_addr"}, ram_rx_valid, 1'b1);
    check({tag, "_din_addr"}, ram_din, v.exp_din_a);
    a_req = 1'b0; b_req = 1'b0;
    @(negedge clk);  // DATA
    check({tag, "_rxv_data"}, ram_rx_valid, 1'b1);
    check({tag, "_din_data"}, ram_din, v.exp_din_d);
    check({tag, "_no_gnt"}, a_gnt | b_gnt, 1'b0);
    ram_tx_valid = 1'b0;
    @(negedge clk);
    n_wait = 0;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      if (v.owner ? b_done : a_done) begin
        seen = 1'b1;
      end else begin
        check({tag, "_wait_quiet"}, {ram_rx_valid, ram_din}, 11'h000);
        n_wait++;
        ram_tx_valid = (n_wait == v.tx_cycle);
        ram_dout = v.dout;
        @(negedge clk);
        ram_tx_valid = 1'b0;
      end
    end
    check({tag, "_done_seen"}, seen, 1'b1);
    check({tag, "_wait_cycles"}, n_wait, v.exp_wait);
    check({tag, "_err_own"}, v.owner ? b_err : a_err, v.exp_err);
    check({tag, "_done_oth"}, v.owner ? {a_done, a_err} : {b_done, b_err}, 2'b00);
    if (v.owner) eb = v.exp_rdata; else ea = v.exp_rdata;
    check({tag, "_a_rdata"}, a_rdata, ea);
    check({tag, "_b_rdata"}, b_rdata, eb);
    @(negedge clk);  // IDLE
    check({tag, "_post_idle"}, {busy, a_done, b_done}, 3'b000);
  endtask

  initial begin
    logic [3:0] order;
    int         n_gnt;
    logic       saw_idle, quiet;

    //            own rd  addr   wdata  dout   tx early din_a    din_d    wt err rdata
    vecs[0] = '{1'b0, 1'b0, 8'h12, 8'hA5, 8'h00, 0, 1'b0, 10'h012, 10'h1A5, 0, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 1'b1, 8'h12, 8'h00, 8'hA5, 1, 1'b0, 10'h212, 10'h300, 1, 1'b0, 8'hA5};
    vecs[2] = '{1'b1, 1'b0, 8'h3C, 8'h5A, 8'h00, 0, 1'b0, 10'h03C, 10'h15A, 0, 1'b0, 8'h00};
    vecs[3] = '{1'b1, 1'b1, 8'hFF, 8'h00, 8'h77, 4, 1'b0, 10'h2FF, 10'h300, 4, 1'b0, 8'h77};
    vecs[4] = '{1'b1, 1'b1, 8'h01, 8'hC3, 8'h99, 0, 1'b0, 10'h201, 10'h300, 4, 1'b1, 8'h77};
    vecs[5] = '{1'b0, 1'b1, 8'h80, 8'h00, 8'hBB, 5, 1'b0, 10'h280, 10'h300, 4, 1'b1, 8'hA5};
    vecs[6] = '{1'b0, 1'b0, 8'h00, 8'hFF, 8'h00, 0, 1'b0, 10'h000, 10'h1FF, 0, 1'b0, 8'hA5};
    vecs[7] = '{1'b0, 1'b1, 8'h7E, 8'h00, 8'h3C, 2, 1'b0, 10'h27E, 10'h300, 2, 1'b0, 8'h3C};
    vecs[8] = '{1'b0, 1'b1, 8'h44, 8'h00, 8'hEE, 0, 1'b1, 10'h244, 10'h300, 4, 1'b1, 8'h3C};

    rst = 1'b1;
    a_req = 1'b0; a_rd = 1'b0; a_addr = 8'h00; a_wdata = 8'h00;
    b_req = 1'b0; b_rd = 1'b0; b_addr = 8'h00; b_wdata = 8'h00;
    ram_tx_valid = 1'b0; ram_dout = 8'h00;
    ea = 8'h00; eb = 8'h00;

    // Reset state, with requests and a RAM strobe present during reset.
    repeat (2) @(negedge clk);
    a_req = 1'b1; b_req = 1'b1; ram_tx_valid = 1'b1; ram_dout = 8'h5F;
    @(negedge clk);
    check("rst_outputs", {busy, ram_rx_valid, ram_din, a_gnt, b_gnt, a_done, b_done, a_err, b_err},
          17'h0);
    check("rst_rdata", {a_rdata, b_rdata}, 16'h0000);
    a_req = 1'b0; b_req = 1'b0; ram_tx_valid = 1'b0;
    rst = 1'b0;

    // Table of single transactions.
    for (int i = 0; i < 9; i++) run_txn($sformatf("v%0d", i), vecs[i]);

    // Stray RAM strobe while idle: nothing changes.
    ram_tx_valid = 1'b1; ram_dout = 8'hD4;
    quiet = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (busy || a_done || b_done) quiet = 1'b0;
    end
    ram_tx_valid = 1'b0;
    check("idle_tx_quiet", quiet, 1'b1);
    check("idle_tx_rdata", {a_rdata, b_rdata}, {ea, eb});

    // Round-robin after reset: both held high -> A, B, A, B.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ea = 8'h00; eb = 8'h00;
    a_rd = 1'b0; b_rd = 1'b0; a_addr = 8'h10; b_addr = 8'h20;
    a_wdata = 8'h11; b_wdata = 8'h22;
    a_req = 1'b1; b_req = 1'b1;
    order = 4'b0000; n_gnt = 0; saw_idle = 1'b0;
    for (int i = 0; i < 40 && n_gnt < 4; i++) begin
      @(negedge clk);
      if (!busy) saw_idle = 1'b1;
      if (a_gnt || b_gnt) begin
        check("rr_onehot", a_gnt & b_gnt, 1'b0);
        if (n_gnt > 0) check("rr_idle_gap", saw_idle, 1'b1);
        check("rr_din", ram_din, b_gnt ? 10'h020 : 10'h010);
        order[n_gnt] = b_gnt;
        n_gnt++;
        saw_idle = 1'b0;
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    check("rr_count", n_gnt, 4);
    check("rr_order", order, 4'b1010);
    for (int i = 0; i < 10 && busy; i++) @(negedge clk);
    check("rr_drain", busy, 1'b0);

    // Reset during DATA of an A write: abandoned at once, no done.
    a_req = 1'b1; a_rd = 1'b0; a_addr = 8'h55; a_wdata = 8'h66;
    @(negedge clk);
    check("rmid_gnt", a_gnt, 1'b1);
    @(negedge clk);
    check("rmid_in_data", ram_din, 10'h166);
    #1 rst = 1'b1;
    #1;
    check("rmid_abort", {ram_rx_valid, ram_din, busy, a_gnt, a_done}, 13'h0);
    a_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    quiet = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (busy || a_done || a_err) quiet = 1'b0;
    end
    check("rmid_no_done", quiet, 1'b1);
    run_txn("rmid_after", '{1'b0, 1'b0, 8'h55, 8'h66, 8'h00, 0, 1'b0,
                            10'h055, 10'h166, 0, 1'b0, 8'h00});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_cmd_arbiter.md
RAM_CMD_ARBITER -- requirements
Module: ram_cmd_arbiter

Interface
REQ-001 SHALL have parameter RD_TIMEOUT, default 4, max WAIT_RD cycles allowed for ram_tx_valid before a read errors.
REQ-002 SHALL have port clk  input  1  single clock; all flops rising-edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have ports a_req / b_req  input  1  requester A/B has a transaction pending; held until its gnt.
REQ-005 SHALL have ports a_rd / b_rd  input  1  1 = read, 0 = write.
REQ-006 SHALL have ports a_addr / b_addr  input  8  RAM address.
REQ-007 SHALL have ports a_wdata / b_wdata  input  8  write data; ignored for reads.
REQ-008 SHALL have ports a_gnt / b_gnt  output  1  one-cycle pulse: transaction captured.
REQ-009 SHALL have ports a_done / b_done  output  1  one-cycle pulse: transaction complete.
REQ-010 SHALL have ports a_err / b_err  output  1  valid with done; 1 = read timeout.
REQ-011 SHALL have ports a_rdata / b_rdata  output  8  read data, valid with done; holds until next read for that requester.
REQ-012 SHALL have port busy  output  1  state != IDLE.
REQ-013 SHALL have port ram_rx_valid  output  1  command strobe to RAM.
REQ-014 SHALL have port ram_din  output  10  RAM command {op[1:0], byte[7:0]}.
REQ-015 SHALL have port ram_tx_valid  input  1  RAM read-data strobe.
REQ-016 SHALL have port ram_dout  input  8  RAM read data.

Function
REQ-017 SHALL implement FSM states IDLE, ADDR, DATA, WAIT_RD, DONE; RAM outputs a Moore decode of state and captured transaction.
REQ-018 SHALL, in IDLE with any req high, at the clock edge capture owner, rd, addr, wdata, go to ADDR, and pulse owner's gnt during the first ADDR cycle.
REQ-019 SHALL arbitrate round-robin: lone requester always wins; both requesting -> requester not last served wins; after reset A has priority.
REQ-020 SHALL, in ADDR, drive ram_rx_valid=1, ram_din={rd,1'b0,addr}; next state DATA.
REQ-021 SHALL, in DATA, drive ram_rx_valid=1, ram_din={rd,1'b1,wdata} for write, {1'b1,1'b1,8'h00} for read; next state DONE (write) or WAIT_RD (read).
REQ-022 SHALL drive ram_rx_valid=0, ram_din=10'h000 in IDLE, WAIT_RD, DONE.
REQ-023 SHALL, in WAIT_RD, count cycles from 0; on ram_tx_valid=1 capture ram_dout into owner's rdata, err=0, go DONE.
REQ-024 SHALL, if ram_tx_valid not seen by the RD_TIMEOUT-th WAIT_RD cycle, go DONE with err=1 and leave owner's rdata unchanged.
REQ-025 SHALL, in DONE, pulse owner's done (and err) for one cycle, then return to IDLE; non-owner done/gnt/err stay 0.
REQ-026 SHALL ignore ram_tx_valid outside WAIT_RD.
REQ-027 SHALL treat req low during a transaction as don't-care (no abort); req still high in IDLE after done starts a new transaction.
REQ-028 SHALL give write latency req-sample -> done = 4 cycles (IDLE, ADDR, DATA, DONE); read with RAM ready = 5 cycles.
REQ-029 SHALL leave at least one IDLE cycle between consecutive transactions.

Reset
REQ-030 SHALL, while rst=1, force state IDLE, all gnt/done/err=0, rdata=8'h00, busy=0, ram_rx_valid=0, ram_din=10'h000, round-robin pointer to A, counter 0.
REQ-031 SHALL, on rst asserted mid-transaction, abandon it immediately without done; first cycle after release is IDLE.

Verification
REQ-032 SHALL cover: A write addr 8'h12 data 8'hA5 -> ram_din 10'h012 then 10'h1A5 on consecutive cycles with ram_rx_valid=1, a_done 2 cycles later, a_err=0.
REQ-033 SHALL cover: A read addr 8'h12 with RAM model returning 8'hA5 one cycle after 10'h300 -> ram_din 10'h212, 10'h300, a_rdata=8'hA5, a_err=0 at a_done.
REQ-034 SHALL cover: a_req and b_req both held high for 4 transactions -> grant order A, B, A, B.
REQ-035 SHALL cover: B read, ram_tx_valid held 0 -> after 4 WAIT_RD cycles b_done=1, b_err=1, b_rdata unchanged.
REQ-036 SHALL cover: rst pulsed during DATA of an A write -> ram_rx_valid=0 immediately, no a_done, busy=0, next a_req served normally.
REQ-037 SHALL cover: ram_tx_valid=1 during IDLE/ADDR -> no rdata change, no done.
